// File: rtl/serial_subtractor_ctrl_if.sv
// Requester <-> serial subtractor bundle: start/A/B request side, ready/busy/done status, registered result.
// Latency: none (wires only).
// Backpressure: requester may only expect start to be taken while ready is high.
// Ports: start, A, B (requester -> controller); ready, busy, done, difference, borrow (controller -> requester).
// Optional macro SUB_FLAGS_EN adds zero and ovf result flags.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrow;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (
        output start, A, B,
        input  ready, busy, done, difference, borrow, zero, ovf
    );
    modport slave (
        input  start, A, B,
        output ready, busy, done, difference, borrow, zero, ovf
    );
`else
    modport master (
        output start, A, B,
        input  ready, busy, done, difference, borrow
    );
    modport slave (
        input  start, A, B,
        output ready, busy, done, difference, borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A-B controller: drives one 1-bit subtract cell LSB first over WIDTH clocks.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE (ready=1); ignored while busy or done, never queued.
// Ports: clk, rst_n (async active-low); bus (slave modport): start/A/B in, ready/busy/done/difference/borrow out.
// Parameters: WIDTH (2..32) operand width; CNT_W bit-counter width, 2**CNT_W >= WIDTH.
// Optional macro SUB_FLAGS_EN: adds registered zero and signed-overflow flags, set alongside the final result.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_subtractor_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_nxt;
    logic             brw_q;       // inter-bit borrow fed back into the cell
    logic             brw_out_q;   // externally visible borrow, untouched by start
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             bn_bit;
    logic             last_bit;

    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // The 1-bit subtract cell operating on the current LSBs.
    assign d_bit    = a_sh[0] ^ b_sh[0] ^ brw_q;
    assign bn_bit   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw_q);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign diff_nxt = {d_bit, diff_sh[WIDTH-1:1]};

    // Next state plus status outputs, decoded from the next state so the
    // status flops line up with the state they describe.
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt == RUN);
        done_nxt  = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Datapath. difference is the result shift register itself: it only
    // moves in RUN, so it holds from done until the next operation shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            diff_sh   <= '0;
            brw_q     <= 1'b0;
            brw_out_q <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        brw_q <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    diff_sh   <= diff_nxt;
                    brw_q     <= bn_bit;
                    brw_out_q <= bn_bit;
                    a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt       <= last_bit ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.difference = diff_sh;
    assign bus.borrow     = brw_out_q;

`ifdef SUB_FLAGS_EN
    // Operand sign bits are gone from the shift registers by the last bit,
    // so they are kept aside at start for the overflow test.
    logic a_msb;
    logic b_msb;
    logic zero_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                a_msb <= bus.A[WIDTH-1];
                b_msb <= bus.B[WIDTH-1];
            end
            // Flags are written on the final bit so they are valid with done.
            if (state == RUN && last_bit) begin
                zero_q <= (diff_nxt == '0);
                ovf_q  <= (a_msb != b_msb) && (d_bit != a_msb);
            end
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Sequences a single 1-bit subtract cell (difference = a^b^bin; borrow = (~a&b) | (~(a^b)&bin)) over a WIDTH-bit operand pair, LSB first, one bit per clock.
- Owns the operand shift registers, the inter-bit borrow flop, the result register, the bit counter and a start/done handshake.
- Sits between a requester issuing A-B operations and the bit-level subtractor datapath.
- Lets the team build multi-bit subtraction from the existing 1-bit cell without a ripple array.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend; captured on the accepted start
B  input  WIDTH  subtrahend; captured on the accepted start
ready  output  1  high in IDLE (start will be accepted)
busy  output  1  high in RUN
done  output  1  one-cycle pulse; result valid
difference  output  WIDTH  A-B modulo 2**WIDTH; held until the next accepted start
borrow  output  1  final borrow out (1 when A<B unsigned); held with difference

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, borrow flop=0, operand shift registers=0.
  - difference=0, borrow=0, done=0, busy=0, ready=1.
  - Takes effect immediately, including mid-RUN; the partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - ready=1.
  - On a clock edge with start=1: a_sh<=A, b_sh<=B, borrow flop<=0, counter<=0, state<=RUN.
  - difference/borrow outputs keep their previous values until the first RUN edge.
- RUN (busy=1, ready=0), on each edge:
  - Compute d and bn from a_sh[0], b_sh[0] and the borrow flop.
  - diff_sh <= {d, diff_sh[WIDTH-1:1]}; borrow flop <= bn.
  - a_sh and b_sh shift right by 1, MSB filled with 0.
  - counter increments.
  - When counter==WIDTH-1 on that edge: state<=DONE, counter<=0.
- DONE: done=1 for exactly one cycle; difference=diff_sh; borrow=borrow flop. Next edge: state<=IDLE.
- Latency: start sampled at edge 0 -> done high during the cycle following edge WIDTH. Throughput: one operation per WIDTH+2 cycles.
- start is ignored in RUN and DONE: no queueing, no effect on the in-flight operation. start held high continuously yields back-to-back operations separated by one IDLE cycle.
- A and B may change freely after the accepted start.
- difference and borrow are registered outputs. They update only while in RUN and DONE, and are stable from done until the next accepted start.
- Arithmetic is unsigned modulo 2**WIDTH; borrow is the MSB-stage borrow out.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SUB_FLAGS_EN
- When defined, two extra registered outputs, both updated with difference in DONE and reset to 0:
  - zero (1 bit): 1 when difference==0.
  - ovf (1 bit): signed two's-complement overflow = (A[MSB]!=B[MSB]) && (difference[MSB]!=A[MSB]), using operand MSBs captured at start.
- When undefined, neither port exists and no flag logic is generated.

Test Plan:
1. WIDTH=8, A=0x5A, B=0x23, start pulse -> done exactly 8 edges after the start edge; difference=0x37, borrow=0; busy high for 8 cycles.
2. A=0x23, B=0x5A -> difference=0xC9, borrow=1. Then A=0x00, B=0x01 -> difference=0xFF, borrow=1.
3. start held high through 3 operations with operand sets changed each time -> each accepted only in IDLE; one IDLE cycle between consecutive done pulses; mid-RUN start edges do not disturb results.
4. Start A=0xF0, B=0x0F; deassert rst_n at RUN cycle 4 -> outputs immediately 0, ready=1, no done. Restart with A=0x10, B=0x01 -> difference=0x0F, borrow=0.
5. SUB_FLAGS_EN defined:
   - A=0x80, B=0x80 -> difference=0x00, zero=1, ovf=0, borrow=0.
   - A=0x80, B=0x01 -> difference=0x7F, ovf=1, zero=0.
   - A=0x7F, B=0xFF -> difference=0x80, ovf=1, borrow=1.
6. Edge widths: WIDTH=2, all 16 A/B combinations -> difference and borrow match (A-B) mod 4 and A<B; done 2 edges after start each time.
